// File: rtl/conv_quant_out_pkg.sv
// Shared lane widths, saturation limits, FSM encoding and the round/saturate helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_quant_out_pkg;

    localparam int ACC_W      = 32;
    localparam int OUT_W      = 8;
    localparam int COEF_W     = 32;
    localparam int SHIFT_BITS = 6;
    localparam int SUM_W      = ACC_W + 1;       // acc + bias without overflow
    localparam int PROD_W     = SUM_W + COEF_W;  // full signed product
    localparam int RND_W      = PROD_W + 1;      // room for the rounding add

    localparam logic signed [OUT_W-1:0] INT8_MAX = 8'sd127;
    localparam logic signed [OUT_W-1:0] INT8_MIN = -8'sd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Round half up, arithmetic shift right, clamp to int8.
    function automatic logic signed [OUT_W-1:0] round_sat(
        input logic signed [PROD_W-1:0]   prod,
        input logic        [SHIFT_BITS-1:0] sh
    );
        logic signed [RND_W-1:0] t;
        t = RND_W'(prod);
        if (sh != '0)
            t = t + (RND_W'(1) <<< (sh - SHIFT_BITS'(1)));
        t = t >>> sh;
        if (t > RND_W'(INT8_MAX))
            return INT8_MAX;
        else if (t < RND_W'(INT8_MIN))
            return INT8_MIN;
        else
            return t[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/conv_quant_out_if.sv
// Accumulator-in / int8-out stream bundle between conv core and write-back.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both directions; a beat moves when valid && ready.
interface conv_quant_out_if #(
    parameter int L     = 8,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
);
    logic [L*ACC_W-1:0] S_Data;
    logic               S_Valid;
    logic               S_Ready;
    logic [L*OUT_W-1:0] M_Data;
    logic               M_Valid;
    logic               M_Ready;

    // Quantizer side: consumes S, produces M.
    modport slave (
        input  S_Data, S_Valid, M_Ready,
        output S_Ready, M_Data, M_Valid
    );

    // Environment side: produces S, consumes M.
    modport master (
        output S_Data, S_Valid, M_Ready,
        input  S_Ready, M_Data, M_Valid
    );
endinterface

// File: rtl/conv_quant_out_quant_lane.sv
// One lane: S1 acc+bias, S2 *scale, S3 round/shift/saturate to int8.
// Latency: 3 enabled cycles from acc to q.
// Backpressure: every register holds while en is low.
module quant_lane
    import conv_quant_out_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [ACC_W-1:0]      acc,
    input  logic signed [COEF_W-1:0]     bias,
    input  logic signed [COEF_W-1:0]     scale,
    input  logic        [SHIFT_BITS-1:0] shift,
    output logic signed [OUT_W-1:0]      q
);
    logic signed [SUM_W-1:0]      s1_sum;
    logic signed [COEF_W-1:0]     s1_scale;
    logic        [SHIFT_BITS-1:0] s1_shift;
    logic signed [PROD_W-1:0]     s2_prod;
    logic        [SHIFT_BITS-1:0] s2_shift;

    // Three-stage datapath; coefficients travel with their beat so a group
    // change never affects beats already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sum   <= '0;
            s1_scale <= '0;
            s1_shift <= '0;
            s2_prod  <= '0;
            s2_shift <= '0;
            q        <= '0;
        end else if (en) begin
            s1_sum   <= SUM_W'(acc) + SUM_W'(bias);
            s1_scale <= scale;
            s1_shift <= shift;
            s2_prod  <= PROD_W'(s1_sum) * PROD_W'(s1_scale);
            s2_shift <= s1_shift;
            q        <= round_sat(s2_prod, s2_shift);
        end
    end
endmodule

// File: rtl/conv_quant_out.sv
// Quantizes the conv accumulator stream to int8 per lane using per-group bias/scale/shift.
// Latency: 3 cycles accept-to-M_Valid; 2-cycle coefficient load at every group start.
// Backpressure: whole pipeline stalls on M_Valid && !M_Ready; S_Ready drops with it.
module conv_quant_out
    import conv_quant_out_pkg::*;
#(
    parameter int PICTURE_NUM             = 1,
    parameter int COMPUTE_CHANNEL_OUT_NUM = 8,
    parameter int WIDTH_DATA_ADD          = 32,
    parameter int WIDTH_DATA              = 8,
    parameter int WIDTH_BIAS_RAM_ADDRA    = 7,
    parameter int WIDTH_FEATURE_SIZE      = 12
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  Start_Cu,
    input  logic [WIDTH_FEATURE_SIZE-1:0]         Row_Num_Out_REG,
    input  logic [WIDTH_FEATURE_SIZE-1:0]         Compute_Times_Channel_Out_REG,
    output logic [WIDTH_BIAS_RAM_ADDRA-1:0]       Bias_Addrb,
    input  logic [32*COMPUTE_CHANNEL_OUT_NUM-1:0] Data_Out_Bias,
    input  logic [32*COMPUTE_CHANNEL_OUT_NUM-1:0] Data_Out_Scale,
    input  logic [32*COMPUTE_CHANNEL_OUT_NUM-1:0] Data_Out_Shift,
    output logic                                  Quant_Complete,
    conv_quant_out_if.slave                       bus
);
    localparam int L = PICTURE_NUM * COMPUTE_CHANNEL_OUT_NUM;
    localparam logic [WIDTH_FEATURE_SIZE-1:0] ONE = WIDTH_FEATURE_SIZE'(1);

    state_t                          state, state_nxt;
    logic [WIDTH_FEATURE_SIZE-1:0]   r_reg, t_reg, pix_cnt, grp_cnt;
    logic                            load_cnt;
    logic                            s1_vld, s2_vld, s3_vld;
    logic                            pipe_en, s_rdy, fire, last_pix, last_grp;
    logic [L*WIDTH_DATA-1:0]         m_dat;
    logic                            shift_unused;

    assign pipe_en        = !s3_vld || bus.M_Ready;
    assign s_rdy          = (state == ST_RUN) && pipe_en;
    assign fire           = bus.S_Valid && s_rdy;
    assign last_pix       = (pix_cnt == r_reg - ONE);
    assign last_grp       = (grp_cnt == t_reg - ONE);
    assign bus.S_Ready    = s_rdy;
    assign bus.M_Valid    = s3_vld;
    assign bus.M_Data     = m_dat;
    assign Bias_Addrb     = grp_cnt[WIDTH_BIAS_RAM_ADDRA-1:0];
    assign Quant_Complete = (state == ST_DONE);
    assign shift_unused   = ^Data_Out_Shift;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> LOAD -> RUN -> (LOAD per group) -> DRAIN -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Start_Cu) begin
                    if (Row_Num_Out_REG == '0 || Compute_Times_Channel_Out_REG == '0)
                        state_nxt = ST_DONE;
                    else
                        state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:  if (load_cnt) state_nxt = ST_RUN;
            ST_RUN: begin
                if (fire && last_pix)
                    state_nxt = last_grp ? ST_DRAIN : ST_LOAD;
            end
            ST_DRAIN: if (!s1_vld && !s2_vld && !s3_vld) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Layer geometry latch and pixel/group counters; group counter doubles as RAM address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg    <= '0;
            t_reg    <= '0;
            pix_cnt  <= '0;
            grp_cnt  <= '0;
            load_cnt <= 1'b0;
        end else begin
            load_cnt <= (state == ST_LOAD) && !load_cnt;
            if (state == ST_IDLE && Start_Cu) begin
                r_reg   <= Row_Num_Out_REG;
                t_reg   <= Compute_Times_Channel_Out_REG;
                pix_cnt <= '0;
                grp_cnt <= '0;
            end else if (fire) begin
                if (last_pix) begin
                    pix_cnt <= '0;
                    grp_cnt <= grp_cnt + ONE;
                end else begin
                    pix_cnt <= pix_cnt + ONE;
                end
            end
        end
    end

    // Stage valids move in lockstep with the lane registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
        end else if (pipe_en) begin
            s1_vld <= fire;
            s2_vld <= s1_vld;
            s3_vld <= s2_vld;
        end
    end

    for (genvar l = 0; l < L; l++) begin : g_lane
        localparam int C = l % COMPUTE_CHANNEL_OUT_NUM;
        quant_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (pipe_en),
            .acc   (bus.S_Data[l*WIDTH_DATA_ADD +: WIDTH_DATA_ADD]),
            .bias  (Data_Out_Bias[C*32 +: 32]),
            .scale (Data_Out_Scale[C*32 +: 32]),
            .shift (Data_Out_Shift[C*32 +: SHIFT_BITS]),
            .q     (m_dat[l*WIDTH_DATA +: WIDTH_DATA])
        );
    end
endmodule

// File: tb/tb_conv_quant_out.sv
// Directed bench for conv_quant_out with a 1-cycle bias RAM model.
// Latency: n/a.
// Backpressure: M_Ready held high or randomly toggled per layer.
module tb_conv_quant_out;
    localparam int C = 8;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start_Cu;
    logic [11:0]  Row_Num_Out_REG;
    logic [11:0]  Compute_Times_Channel_Out_REG;
    logic [6:0]   Bias_Addrb;
    logic [255:0] Data_Out_Bias, Data_Out_Scale, Data_Out_Shift;
    logic         Quant_Complete;

    conv_quant_out_if #(.L(L), .ACC_W(32), .OUT_W(8)) bus ();

    conv_quant_out dut (
        .clk                           (clk),
        .rst                           (rst),
        .Start_Cu                      (Start_Cu),
        .Row_Num_Out_REG               (Row_Num_Out_REG),
        .Compute_Times_Channel_Out_REG (Compute_Times_Channel_Out_REG),
        .Bias_Addrb                    (Bias_Addrb),
        .Data_Out_Bias                 (Data_Out_Bias),
        .Data_Out_Scale                (Data_Out_Scale),
        .Data_Out_Shift                (Data_Out_Shift),
        .Quant_Complete                (Quant_Complete),
        .bus                           (bus)
    );

    always #5 clk = ~clk;

    // Bias/scale/shift RAM: one row per group, same value on every channel.
    logic [31:0] bias_mem [0:127];
    logic [31:0] scale_mem[0:127];
    logic [31:0] shift_mem[0:127];
    always @(posedge clk) begin
        Data_Out_Bias  <= {C{bias_mem[Bias_Addrb]}};
        Data_Out_Scale <= {C{scale_mem[Bias_Addrb]}};
        Data_Out_Shift <= {C{shift_mem[Bias_Addrb]}};
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [255:0] in_q[$];
    logic [63:0]  exp_q[$];
    logic [63:0]  out_q[$];
    logic [6:0]   addr_q[$];
    int           fire_cyc[$];
    int           first_mv, qc_cnt, qc_outs, srdy_cnt, loop_cycles;
    bit           layer_done;
    bit           hold;
    logic [63:0]  hold_dat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: collects accepted beats, checks hold stability, counts pulses.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chki("hold_valid", int'(bus.M_Valid), 1);
                chk("hold_data", bus.M_Data, hold_dat);
            end
            if (bus.M_Valid && bus.M_Ready) out_q.push_back(bus.M_Data);
            if (bus.M_Valid && first_mv < 0) first_mv = cyc;
            if (Quant_Complete) begin
                qc_cnt++;
                qc_outs = out_q.size();
            end
            if (bus.S_Ready) srdy_cnt++;
            hold     = bus.M_Valid && !bus.M_Ready;
            hold_dat = bus.M_Data;
        end
    end

    task automatic set_grp(input int g, input int b, input int s, input int sh);
        bias_mem[g]  = 32'(b);
        scale_mem[g] = 32'(s);
        shift_mem[g] = 32'(sh);
    endtask

    // Runs one layer; stops early after max_fire accepted beats (no completion wait then).
    task automatic run_layer(input int r, input int t, input bit rnd, input int max_fire);
        int idx = 0;
        bit fire;
        out_q.delete(); addr_q.delete(); fire_cyc.delete();
        first_mv = -1; qc_cnt = 0; qc_outs = -1; srdy_cnt = 0;
        layer_done = 1'b0; loop_cycles = 0;
        Row_Num_Out_REG = 12'(r);
        Compute_Times_Channel_Out_REG = 12'(t);
        Start_Cu = 1'b1;
        @(posedge clk); #1;
        Start_Cu = 1'b0;
        while (!layer_done && loop_cycles < 2000 && idx < max_fire) begin
            bus.S_Valid = (idx < in_q.size());
            bus.S_Data  = bus.S_Valid ? in_q[idx] : '0;
            bus.M_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            fire = bus.S_Valid && bus.S_Ready;
            if (fire) begin
                addr_q.push_back(Bias_Addrb);
                fire_cyc.push_back(cyc);
            end
            if (Quant_Complete) layer_done = 1'b1;
            @(posedge clk); #1;
            if (fire) idx++;
            loop_cycles++;
        end
        bus.S_Valid = 1'b0;
        bus.M_Ready = 1'b1;
        if (max_fire > in_q.size()) begin
            chki("layer_done", int'(layer_done), 1);
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outputs(input string tag);
        chki({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk(tag, out_q[i], exp_q[i]);
    endtask

    initial begin
        logic [255:0] d;
        logic [63:0]  e;
        int mix_acc[8];
        int mix_exp[8];
        mix_acc = '{5, -5, 6, -6, 7, -7, 0, 255};
        mix_exp = '{3, -2, 3, -3, 4, -3, 0, 127};

        for (int g = 0; g < 128; g++) set_grp(g, 0, 1, 0);
        rst = 1'b1; Start_Cu = 1'b0; bus.S_Valid = 1'b0; bus.S_Data = '0; bus.M_Ready = 1'b1;
        Row_Num_Out_REG = '0; Compute_Times_Channel_Out_REG = '0;
        repeat (3) @(posedge clk);
        #1;
        chki("rst_s_ready", int'(bus.S_Ready), 0);
        chki("rst_m_valid", int'(bus.M_Valid), 0);
        chk("rst_m_data", bus.M_Data, 64'h0);
        chki("rst_addr", int'(Bias_Addrb), 0);
        chki("rst_qc", int'(Quant_Complete), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic: (100+28)*3=384, +2 round, >>2 -> 96.
        set_grp(0, 28, 3, 2);
        in_q.delete(); exp_q.delete();
        for (int b = 0; b < 4; b++) begin
            in_q.push_back({L{32'd100}});
            exp_q.push_back({L{8'd96}});
        end
        run_layer(4, 1, 1'b0, 100);
        check_outputs("basic");
        chki("basic_latency", first_mv - fire_cyc[0], 3);
        chki("basic_qc_count", qc_cnt, 1);
        chki("basic_qc_after_last", qc_outs, 4);

        // Saturation and rounding: group 0 shift 0, group 1 shift 1.
        set_grp(0, 0, 1, 0);
        set_grp(1, 0, 1, 1);
        in_q.delete(); exp_q.delete();
        in_q.push_back({L{32'd1000000}});   exp_q.push_back({L{8'h7f}});
        in_q.push_back({L{-32'sd1000000}}); exp_q.push_back({L{8'h80}});
        in_q.push_back({L{-32'sd3}});       exp_q.push_back({L{8'hff}});
        for (int i = 0; i < L; i++) begin
            d[i*32 +: 32] = 32'(mix_acc[i]);
            e[i*8 +: 8]   = 8'(mix_exp[i]);
        end
        in_q.push_back(d); exp_q.push_back(e);
        run_layer(2, 2, 1'b0, 100);
        check_outputs("sat_round");

        // Multi-group: bias g*10, outputs 0,0,10,10,20,20; 2 stall cycles per boundary.
        for (int g = 0; g < 3; g++) set_grp(g, g * 10, 1, 0);
        in_q.delete(); exp_q.delete();
        for (int b = 0; b < 6; b++) begin
            in_q.push_back('0);
            exp_q.push_back({L{8'((b / 2) * 10)}});
        end
        run_layer(2, 3, 1'b0, 100);
        check_outputs("groups");
        for (int i = 0; i < 6 && i < addr_q.size(); i++)
            chki("groups_addr", int'(addr_q[i]), i / 2);
        if (fire_cyc.size() == 6) begin
            chki("groups_in_group_gap", fire_cyc[1] - fire_cyc[0], 1);
            chki("groups_boundary_gap0", fire_cyc[2] - fire_cyc[1], 3);
            chki("groups_boundary_gap1", fire_cyc[4] - fire_cyc[3], 3);
        end else begin
            chki("groups_fire_count", fire_cyc.size(), 6);
        end

        // Random backpressure, identity coefficients: order and count preserved.
        set_grp(0, 0, 1, 0);
        set_grp(1, 0, 1, 0);
        in_q.delete(); exp_q.delete();
        for (int b = 0; b < 32; b++) begin
            for (int i = 0; i < L; i++) begin
                d[i*32 +: 32] = 32'(b + i * 10);
                e[i*8 +: 8]   = 8'(b + i * 10);
            end
            in_q.push_back(d); exp_q.push_back(e);
        end
        run_layer(16, 2, 1'b1, 100);
        check_outputs("random_bp");
        chki("random_qc_count", qc_cnt, 1);

        // Empty layer: immediate completion, never ready.
        in_q.delete(); exp_q.delete();
        run_layer(4, 0, 1'b0, 100);
        chki("t0_qc_fast", int'(loop_cycles <= 2), 1);
        chki("t0_qc_count", qc_cnt, 1);
        chki("t0_s_ready", srdy_cnt, 0);

        // Reset after 5 of 8 beats, then a clean layer.
        set_grp(0, 28, 3, 2);
        in_q.delete(); exp_q.delete();
        for (int b = 0; b < 8; b++) in_q.push_back({L{32'd100}});
        run_layer(8, 1, 1'b0, 5);
        rst = 1'b1;
        #1;
        chki("midrst_m_valid", int'(bus.M_Valid), 0);
        chki("midrst_s_ready", int'(bus.S_Ready), 0);
        chki("midrst_addr", int'(Bias_Addrb), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        in_q.delete(); exp_q.delete();
        for (int b = 0; b < 4; b++) begin
            in_q.push_back({L{32'd100}});
            exp_q.push_back({L{8'd96}});
        end
        run_layer(4, 1, 1'b0, 100);
        check_outputs("after_rst");
        if (addr_q.size() > 0) chki("after_rst_addr", int'(addr_q[0]), 0);
        chki("after_rst_qc", qc_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
